// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-Lite response codes and read-adapter state encoding.
package axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, REQ, RESP} rd_state_t;
endpackage

// File: rtl/axil_reg_rd_if.sv
// axil_reg_rd_if: AXI-Lite AR/R channel bundle with master/slave views.
interface axil_reg_rd_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  modport master (output araddr, arprot, arvalid, rready, input arready, rdata, rresp, rvalid);
  modport slave  (input araddr, arprot, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/axil_timeout_ctr.sv
// axil_timeout_ctr: loadable down-counter that saturates at zero and flags it.
module axil_timeout_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/axil_reg_rd.sv
// axil_reg_rd: AXI-Lite read slave to register read strobe bridge with ack timeout.
// Define AXIL_RD_SLVERR_EN to return SLVERR on timeout and expose err_timeout.
module axil_reg_rd
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 40,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  axil_reg_rd_if.slave          s_axil,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
`ifdef AXIL_RD_SLVERR_EN
  ,
  output logic                  err_timeout
`endif
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);
`ifdef AXIL_RD_SLVERR_EN
  localparam logic [1:0] TO_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] TO_RESP = RESP_OKAY;
`endif
  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  en_q, en_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ar_hs, ack_hit, to_hit, r_hs, zero;
  logic                  unused_arprot;
  assign unused_arprot = ^s_axil.arprot;
  assign s_axil.arready = (state_q == IDLE) && rstn;
  assign ar_hs   = s_axil.arvalid && s_axil.arready;
  assign ack_hit = (state_q == REQ) && reg_rd_ack;
  // ack takes priority over a coinciding timeout so valid data is never dropped
  assign to_hit  = (state_q == REQ) && !reg_rd_ack && zero && !reg_rd_wait;
  assign r_hs    = (state_q == RESP) && s_axil.rready;
  axil_timeout_ctr #(.W(CW)) u_ctr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (ar_hs),
    .load_val (LOAD_VAL),
    .dec      ((state_q == REQ) && !reg_rd_wait),
    .zero     (zero)
  );
  always_comb begin
    state_d  = ar_hs ? REQ : (ack_hit || to_hit) ? RESP : r_hs ? IDLE : state_q;
    addr_d   = ar_hs ? s_axil.araddr : addr_q;
    en_d     = ar_hs ? 1'b1 : (ack_hit || to_hit) ? 1'b0 : en_q;
    rdata_d  = ack_hit ? reg_rd_data : to_hit ? '0 : rdata_q;
    rresp_d  = ack_hit ? RESP_OKAY : to_hit ? TO_RESP : rresp_q;
    rvalid_d = (ack_hit || to_hit) ? 1'b1 : r_hs ? 1'b0 : rvalid_q;
  end
`ifdef AXIL_RD_SLVERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= to_hit;
  end
  assign err_timeout = err_q;
`endif
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      en_q     <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign reg_rd_addr   = addr_q;
  assign reg_rd_en     = en_q;
  assign s_axil.rdata  = rdata_q;
  assign s_axil.rresp  = rresp_q;
  assign s_axil.rvalid = rvalid_q;
endmodule

// File: tb/tb_axil_reg_rd.sv
// tb_axil_reg_rd: directed reads with a scoreboard queue checked by an R-channel monitor.
module tb_axil_reg_rd;
  import axil_pkg::*;
  localparam int AW = 40;
  localparam int DW = 32;
`ifdef AXIL_RD_SLVERR_EN
  localparam logic [1:0] TO_RESP = 2'b10;
`else
  localparam logic [1:0] TO_RESP = 2'b00;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  logic [AW-1:0] reg_rd_addr;
  logic          reg_rd_en;
  logic [DW-1:0] reg_rd_data;
  logic          reg_rd_wait;
  logic          reg_rd_ack;
`ifdef AXIL_RD_SLVERR_EN
  logic          err_timeout;
`endif
  axil_reg_rd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  axil_reg_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_axil      (bus),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (reg_rd_data),
    .reg_rd_wait (reg_rd_wait),
    .reg_rd_ack  (reg_rd_ack)
`ifdef AXIL_RD_SLVERR_EN
    ,
    .err_timeout (err_timeout)
`endif
  );
  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } exp_t;
  exp_t sb[$];
  int n_pass = 0;
  int n_chk = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.rvalid && bus.rready) begin
      if (sb.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("mon_rdata", 64'(bus.rdata), 64'(e.data));
        chk("mon_rresp", 64'(bus.rresp), 64'(e.resp));
      end
    end
  end
  task automatic rd(input string tag, input logic [AW-1:0] addr, input int ack_at,
                    input logic [DW-1:0] data, input int w_lo, input int w_hi,
                    input int stall, input int exp_vc, input bit to);
    int c;
    int vc;
    vc = -1;
    bus.araddr  = addr;
    bus.arprot  = 3'b010;
    bus.arvalid = 1'b1;
    bus.rready  = (stall == 0);
    chk({tag, "_arready_idle"}, 64'(bus.arready), 64'd1);
    cyc();
    bus.arvalid = 1'b0;
    c = 1;
    chk({tag, "_en_c1"}, 64'(reg_rd_en), 64'd1);
    chk({tag, "_addr_c1"}, 64'(reg_rd_addr), 64'(addr));
    sb.push_back('{data: to ? '0 : data, resp: to ? TO_RESP : RESP_OKAY});
    while (vc < 0 && c < 40) begin
      reg_rd_ack  = (c == ack_at);
      reg_rd_data = data;
      reg_rd_wait = (c >= w_lo && c <= w_hi);
      cyc();
      c++;
      if (bus.rvalid) vc = c;
    end
    reg_rd_ack  = 1'b0;
    reg_rd_wait = 1'b0;
    chk({tag, "_rvalid_cycle"}, 64'(vc), 64'(exp_vc));
    chk({tag, "_en_done"}, 64'(reg_rd_en), 64'd0);
`ifdef AXIL_RD_SLVERR_EN
    chk({tag, "_err_pulse"}, 64'(err_timeout), 64'(to));
`endif
    for (int i = 0; i < stall; i++) begin
      bus.araddr  = addr + 40'h10;
      bus.arvalid = 1'b1;
      chk({tag, "_arready_stall"}, 64'(bus.arready), 64'd0);
      chk({tag, "_rdata_stable"}, 64'(bus.rdata), 64'(to ? '0 : data));
      chk({tag, "_rvalid_stable"}, 64'(bus.rvalid), 64'd1);
      cyc();
    end
    bus.rready = 1'b1;
    cyc();
    chk({tag, "_arready_after"}, 64'(bus.arready), 64'd1);
    chk({tag, "_rvalid_after"}, 64'(bus.rvalid), 64'd0);
`ifdef AXIL_RD_SLVERR_EN
    chk({tag, "_err_clear"}, 64'(err_timeout), 64'd0);
`endif
  endtask
  initial begin
    int bad;
    bus.araddr  = '0;
    bus.arprot  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    reg_rd_ack  = 1'b0;
    reg_rd_wait = 1'b0;
    reg_rd_data = '0;
    cyc();
    cyc();
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_en", 64'(reg_rd_en), 64'd0);
    chk("rst_addr", 64'(reg_rd_addr), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_rresp", 64'(bus.rresp), 64'd0);
    rstn = 1'b1;
    #1;
    chk("rel_arready", 64'(bus.arready), 64'd1);
    rd("single", 40'h10, 1, 32'hDEADBEEF, 1, 0, 0, 2, 1'b0);
    rd("timeout", 40'h40, -1, 32'hCAFEF00D, 1, 0, 0, 5, 1'b1);
    rd("wait", 40'h50, 12, 32'h00001234, 1, 10, 0, 13, 1'b0);
    rd("bp", 40'h20, 2, 32'h55AA00FF, 1, 0, 5, 3, 1'b0);
    rd("bp2", 40'h30, 1, 32'h0BADF00D, 1, 0, 0, 2, 1'b0);
    rd("ack0", 40'h60, 4, 32'hA5A5A5A5, 1, 0, 0, 5, 1'b0);
    bus.araddr  = 40'h70;
    bus.arvalid = 1'b1;
    chk("mid_arready", 64'(bus.arready), 64'd1);
    cyc();
    bus.arvalid = 1'b0;
    chk("mid_en_c1", 64'(reg_rd_en), 64'd1);
    cyc();
    rstn = 1'b0;
    #1;
    chk("mid_arready_gated", 64'(bus.arready), 64'd0);
    cyc();
    chk("mid_en_dropped", 64'(reg_rd_en), 64'd0);
    chk("mid_rvalid", 64'(bus.rvalid), 64'd0);
    chk("mid_addr", 64'(reg_rd_addr), 64'd0);
    chk("mid_arready_held", 64'(bus.arready), 64'd0);
    rstn = 1'b1;
    #1;
    chk("mid_arready_rel", 64'(bus.arready), 64'd1);
    bad = 0;
    repeat (6) begin
      if (bus.rvalid || reg_rd_en) bad++;
      cyc();
    end
    chk("mid_no_rbeat", 64'(bad), 64'd0);
    rd("post_rst", 40'h80, 1, 32'h13579BDF, 1, 0, 0, 2, 1'b0);
    cyc();
    cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
